// File: rtl/io_responder_pkg.sv
// Shared definitions for the memory-mapped I/O responder: register addresses,
// control-register bit positions and the status update rule used by both input groups.
package io_defs;

  localparam logic [15:0] IO_KDATA    = 16'hFFF0;
  localparam logic [15:0] IO_SDATA    = 16'hFFF2;
  localparam logic [15:0] IO_KCTRL    = 16'hFFF4;
  localparam logic [15:0] IO_SCTRL    = 16'hFFF6;
  localparam logic [15:0] IO_HEX      = 16'hFFF8;
  localparam logic [15:0] IO_LEDR     = 16'hFFFA;
  localparam logic [15:0] IO_LEDG     = 16'hFFFC;
  localparam logic [15:0] IO_UNMAPPED = 16'hDEAD;

  localparam int CTRL_READY = 0;
  localparam int CTRL_OVR   = 2;

  typedef enum logic [2:0] {
    SEL_KDATA = 3'd0,
    SEL_SDATA = 3'd1,
    SEL_KCTRL = 3'd2,
    SEL_SCTRL = 3'd3,
    SEL_HEX   = 3'd4,
    SEL_LEDR  = 3'd5,
    SEL_LEDG  = 3'd6,
    SEL_RSVD  = 3'd7
  } io_sel_e;

  typedef struct packed {
    logic ovr;
    logic ready;
  } io_status_t;

  // Registers are word-aligned, so the byte-address LSB never takes part in decode.
  function automatic io_sel_e io_decode(input logic [15:0] addr);
    io_sel_e sel;
    case ({addr[15:1], 1'b0})
      IO_KDATA: sel = SEL_KDATA;
      IO_SDATA: sel = SEL_SDATA;
      IO_KCTRL: sel = SEL_KCTRL;
      IO_SCTRL: sel = SEL_SCTRL;
      IO_HEX:   sel = SEL_HEX;
      IO_LEDR:  sel = SEL_LEDR;
      IO_LEDG:  sel = SEL_LEDG;
      default:  sel = SEL_RSVD;
    endcase
    return sel;
  endfunction

  // Set events win over clears for both Ready and Overrun.
  function automatic io_status_t status_next(input io_status_t cur, input logic commit,
                                             input logic rd_clr, input logic ovr_clr);
    io_status_t nxt;
    nxt = cur;
    if (commit) begin
      nxt.ready = 1'b1;
    end else if (rd_clr) begin
      nxt.ready = 1'b0;
    end else begin
      nxt.ready = cur.ready;
    end
    if (commit && cur.ready && !rd_clr) begin
      nxt.ovr = 1'b1;
    end else if (ovr_clr) begin
      nxt.ovr = 1'b0;
    end else begin
      nxt.ovr = cur.ovr;
    end
    return nxt;
  endfunction

  function automatic logic [15:0] ctrl_word(input io_status_t st);
    logic [15:0] w;
    w = 16'h0000;
    w[CTRL_READY] = st.ready;
    w[CTRL_OVR]   = st.ovr;
    return w;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Group debouncer: 2-flop synchronizer, candidate/counter and committed value.
// changed_o pulses in the cycle whose clock edge commits a new value (DB_CYCLES >= 2).
module io_debounce
  import io_defs::*;
#(
  parameter int WIDTH     = 4,
  parameter int DB_CYCLES = 500000,
  parameter int CNTBITS   = 20
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] value_o,
  output logic             changed_o
);

  // The load cycle counts as the first stable sample, hence DB_CYCLES-2.
  localparam logic [CNTBITS-1:0] CNT_LAST = CNTBITS'(DB_CYCLES - 2);
  localparam logic [CNTBITS-1:0] CNT_ZERO = {CNTBITS{1'b0}};
  localparam logic [CNTBITS-1:0] CNT_ONE  = {{(CNTBITS-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]   sync1_q, sync2_q;
  logic [WIDTH-1:0]   cand_q, cand_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic [CNTBITS-1:0] cnt_q, cnt_d;
  logic               commit_s;

  // Candidate tracking and commit decision.
  always_comb begin
    cand_d   = cand_q;
    value_d  = value_q;
    cnt_d    = cnt_q;
    commit_s = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = CNT_ZERO;
    end else if (cand_q != value_q) begin
      if (cnt_q == CNT_LAST) begin
        value_d  = cand_q;
        cnt_d    = CNT_ZERO;
        commit_s = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset returns everything to the idle (released) value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= {WIDTH{1'b0}};
      sync2_q <= {WIDTH{1'b0}};
      cand_q  <= {WIDTH{1'b0}};
      value_q <= {WIDTH{1'b0}};
      cnt_q   <= CNT_ZERO;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end

  assign value_o   = value_q;
  assign changed_o = commit_s;

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O responder at FFF0-FFFE: debounced keys/switches with sticky
// Ready/Overrun status, plus the HEX/LEDR/LEDG display registers. DBITS is 16.
module io_responder
  import io_defs::*;
#(
  parameter int DBITS     = 16,
  parameter int DB_CYCLES = 500000,
  parameter int CNTBITS   = 20
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [DBITS-1:0] ADDR,
  input  logic [DBITS-1:0] DIN,
  input  logic             WE,
  input  logic             RE,
  output logic [DBITS-1:0] DOUT,
  output logic             HIT,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [15:0]      HEX,
  output logic [9:0]       LEDR,
  output logic [7:0]       LEDG
);

  logic [3:0] key_val_s;
  logic [9:0] sw_val_s;
  logic       key_chg_s, sw_chg_s;
  logic       hit_s, wr_s;
  io_sel_e    sel_s;

  logic [15:0] hex_q, hex_d;
  logic [9:0]  ledr_q, ledr_d;
  logic [7:0]  ledg_q, ledg_d;
  io_status_t  kst_q, kst_d, sst_q, sst_d;
  logic [15:0] dout_s;

  // Keys are active-low at the pins; invert so pressed reads as 1.
  io_debounce #(.WIDTH(4), .DB_CYCLES(DB_CYCLES), .CNTBITS(CNTBITS)) u_key_db (
    .clk_i     (CLK),
    .rst_n_i   (RESET_N),
    .raw_i     (~KEY),
    .value_o   (key_val_s),
    .changed_o (key_chg_s)
  );

  io_debounce #(.WIDTH(10), .DB_CYCLES(DB_CYCLES), .CNTBITS(CNTBITS)) u_sw_db (
    .clk_i     (CLK),
    .rst_n_i   (RESET_N),
    .raw_i     (SW),
    .value_o   (sw_val_s),
    .changed_o (sw_chg_s)
  );

  assign hit_s = (ADDR[15:4] == 12'hFFF);
  assign sel_s = io_decode(ADDR[15:0]);
  assign wr_s  = WE & hit_s;

  // Register writes and status updates.
  always_comb begin
    hex_d  = hex_q;
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    kst_d  = status_next(kst_q, key_chg_s, RE & hit_s & (sel_s == SEL_KDATA),
                         wr_s & (sel_s == SEL_KCTRL) & ~DIN[CTRL_OVR]);
    sst_d  = status_next(sst_q, sw_chg_s, RE & hit_s & (sel_s == SEL_SDATA),
                         wr_s & (sel_s == SEL_SCTRL) & ~DIN[CTRL_OVR]);
    if (wr_s) begin
      case (sel_s)
        SEL_HEX:  hex_d  = DIN[15:0];
        SEL_LEDR: ledr_d = DIN[9:0];
        SEL_LEDG: ledg_d = DIN[7:0];
        default:  hex_d  = hex_q;
      endcase
    end else begin
      hex_d = hex_q;
    end
  end

  // Register state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hex_q  <= 16'h0000;
      ledr_q <= 10'h000;
      ledg_q <= 8'h00;
      kst_q  <= '{ovr: 1'b0, ready: 1'b0};
      sst_q  <= '{ovr: 1'b0, ready: 1'b0};
    end else begin
      hex_q  <= hex_d;
      ledr_q <= ledr_d;
      ledg_q <= ledg_d;
      kst_q  <= kst_d;
      sst_q  <= sst_d;
    end
  end

  // Combinational read mux; unmapped space answers with a recognisable marker.
  always_comb begin
    dout_s = IO_UNMAPPED;
    if (hit_s) begin
      case (sel_s)
        SEL_KDATA: dout_s = {12'h000, key_val_s};
        SEL_SDATA: dout_s = {6'h00, sw_val_s};
        SEL_KCTRL: dout_s = ctrl_word(kst_q);
        SEL_SCTRL: dout_s = ctrl_word(sst_q);
        SEL_HEX:   dout_s = hex_q;
        SEL_LEDR:  dout_s = {6'h00, ledr_q};
        SEL_LEDG:  dout_s = {8'h00, ledg_q};
        default:   dout_s = 16'h0000;
      endcase
    end else begin
      dout_s = IO_UNMAPPED;
    end
  end

  assign DOUT = DBITS'(dout_s);
  assign HIT  = hit_s;
  assign HEX  = hex_q;
  assign LEDR = ledr_q;
  assign LEDG = ledg_q;

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder: directed plan items plus random bus/pin
// traffic checked against a history-based reference model.
module tb_io_responder;

  localparam int DB = 4;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [15:0] ADDR, DIN, DOUT;
  logic        WE, RE, HIT;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [15:0] HEX;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;

  always #5 CLK = ~CLK;

  io_responder #(.DBITS(16), .DB_CYCLES(DB), .CNTBITS(3)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ADDR(ADDR), .DIN(DIN), .WE(WE), .RE(RE),
    .DOUT(DOUT), .HIT(HIT), .KEY(KEY), .SW(SW), .HEX(HEX), .LEDR(LEDR), .LEDG(LEDG)
  );

  typedef struct {
    string       name;
    int          kind;   // 0 DOUT+HIT, 1 HEX, 2 LEDR, 3 LEDG
    logic [15:0] exp;
    logic        exp_hit;
  } chk_t;

  chk_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  logic [9:0]  khist[$], shist[$];
  logic [3:0]  m_kval;
  logic [9:0]  m_sval;
  logic        m_krdy, m_kovr, m_srdy, m_sovr;
  logic [15:0] m_hex;
  logic [9:0]  m_ledr;
  logic [7:0]  m_ledg;

  task automatic model_reset();
    khist.delete(); shist.delete();
    m_kval = 4'h0; m_sval = 10'h000;
    m_krdy = 1'b0; m_kovr = 1'b0; m_srdy = 1'b0; m_sovr = 1'b0;
    m_hex = 16'h0000; m_ledr = 10'h000; m_ledg = 8'h00;
  endtask

  function automatic logic [9:0] at(input logic [9:0] h[$], input int idx);
    if (idx < 0) return 10'h000;
    return h[idx];
  endfunction

  // A value commits once it has been the synchronized sample for exactly DB
  // consecutive edges (the sample at an edge is the pin two edges earlier).
  function automatic logic [10:0] run_commit(input logic [9:0] h[$], input logic [9:0] cur);
    logic [9:0] x;
    bit stable;
    int top;
    top = h.size() - 3;
    x = at(h, top);
    stable = 1'b1;
    for (int i = 1; i < DB; i++) if (at(h, top - i) != x) stable = 1'b0;
    return {(stable && (at(h, top - DB) != x) && (x != cur)), x};
  endfunction

  task automatic model_edge();
    logic [10:0] kc, sc;
    logic hit, k_rd, s_rd, k_w0, s_w0;
    logic [15:0] a;
    if (!RESET_N) begin
      model_reset();
      return;
    end
    khist.push_back({6'b0, ~KEY});
    if (khist.size() > DB + 3) void'(khist.pop_front());
    shist.push_back(SW);
    if (shist.size() > DB + 3) void'(shist.pop_front());
    kc = run_commit(khist, {6'b0, m_kval});
    sc = run_commit(shist, m_sval);
    hit  = (ADDR[15:4] == 12'hFFF);
    a    = {ADDR[15:1], 1'b0};
    k_rd = RE && hit && (a == 16'hFFF0);
    s_rd = RE && hit && (a == 16'hFFF2);
    k_w0 = WE && hit && (a == 16'hFFF4) && !DIN[2];
    s_w0 = WE && hit && (a == 16'hFFF6) && !DIN[2];
    if (kc[10] && m_krdy && !k_rd) m_kovr = 1'b1; else if (k_w0) m_kovr = 1'b0;
    if (kc[10]) m_krdy = 1'b1; else if (k_rd) m_krdy = 1'b0;
    if (kc[10]) m_kval = kc[3:0];
    if (sc[10] && m_srdy && !s_rd) m_sovr = 1'b1; else if (s_w0) m_sovr = 1'b0;
    if (sc[10]) m_srdy = 1'b1; else if (s_rd) m_srdy = 1'b0;
    if (sc[10]) m_sval = sc[9:0];
    if (WE && hit) begin
      if (a == 16'hFFF8) m_hex = DIN;
      if (a == 16'hFFFA) m_ledr = DIN[9:0];
      if (a == 16'hFFFC) m_ledg = DIN[7:0];
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [15:0] addr);
    if (addr[15:4] != 12'hFFF) return 16'hDEAD;
    case (addr[3:1])
      3'd0: return {12'h000, m_kval};
      3'd1: return {6'h00, m_sval};
      3'd2: return {13'h0, m_kovr, 1'b0, m_krdy};
      3'd3: return {13'h0, m_sovr, 1'b0, m_srdy};
      3'd4: return m_hex;
      3'd5: return {6'h00, m_ledr};
      3'd6: return {8'h00, m_ledg};
      default: return 16'h0000;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic we, input logic re, input logic [15:0] addr, input logic [15:0] din);
    @(posedge CLK);
    model_edge();
    #1;
    WE = we; RE = re; ADDR = addr; DIN = din;
  endtask

  task automatic expect_out(input string name, input int kind, input logic [15:0] exp);
    chk_t c;
    c.name = name; c.kind = kind; c.exp = exp; c.exp_hit = (ADDR[15:4] == 12'hFFF);
    sbq.push_back(c);
  endtask

  task automatic rd(input logic [15:0] addr, input string name, input logic [15:0] exp);
    step(1'b0, 1'b0, addr, 16'h0000);
    expect_out(name, 0, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // ---------------- monitor ----------------
  initial begin
    chk_t c;
    logic [15:0] act;
    logic act_hit;
    forever begin
      @(negedge CLK);
      while (sbq.size() > 0) begin
        c = sbq.pop_front();
        act_hit = c.exp_hit;
        case (c.kind)
          0: begin act = DOUT; act_hit = HIT; end
          1: act = HEX;
          2: act = {6'h00, LEDR};
          3: act = {8'h00, LEDG};
          default: act = 16'hXXXX;
        endcase
        n_cmp++;
        if (act !== c.exp || act_hit !== c.exp_hit) begin
          n_bad++;
          $display("FAIL %s: got %h (hit %b), want %h (hit %b)", c.name, act, act_hit, c.exp, c.exp_hit);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    RESET_N = 1'b0; KEY = 4'hF; SW = 10'h000;
    WE = 1'b0; RE = 1'b0; ADDR = 16'h0000; DIN = 16'h0000;
    model_reset();
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;

    // reset state
    rd(16'hFFF0, "rst_kdata", 16'h0000);
    rd(16'hFFF4, "rst_kctrl", 16'h0000);
    rd(16'hFFF8, "rst_hex", 16'h0000);
    rd(16'h0100, "unmapped", 16'hDEAD);

    // display registers
    step(1'b1, 1'b0, 16'hFFF8, 16'hBEEF);
    step(1'b1, 1'b0, 16'hFFFA, 16'h03FF);
    step(1'b1, 1'b0, 16'hFFFC, 16'h01A5);
    step(1'b1, 1'b0, 16'hFFFE, 16'h1234);
    step(1'b1, 1'b0, 16'hFFF0, 16'h000F);
    rd(16'hFFFC, "ledg_rb", 16'h00A5);
    expect_out("hex_pin", 1, 16'hBEEF);
    expect_out("ledr_pin", 2, 16'h03FF);
    expect_out("ledg_pin", 3, 16'h00A5);
    rd(16'hFFFF, "rsvd_rd", 16'h0000);
    rd(16'hFFF1, "kdata_ro", 16'h0000);

    // key commit latency: 2 sync + DB stable edges
    KEY = 4'b1110;
    idle(4);
    rd(16'hFFF0, "kdata_pre", 16'h0000);
    rd(16'hFFF0, "kdata_commit", 16'h0001);
    rd(16'hFFF4, "kctrl_ready", 16'h0001);
    step(1'b0, 1'b1, 16'hFFF0, 16'h0000);
    expect_out("kdata_rd", 0, 16'h0001);
    rd(16'hFFF4, "kctrl_clr", 16'h0000);

    // switch glitch shorter than DB never commits
    SW = 10'h155;
    idle(3);
    SW = 10'h000;
    idle(8);
    rd(16'hFFF2, "sdata_glitch", 16'h0000);
    rd(16'hFFF6, "sctrl_glitch", 16'h0000);

    // two commits without a read -> overrun, then write-0 clear
    KEY = 4'b1100;
    idle(5);
    rd(16'hFFF4, "kctrl_c1", 16'h0001);
    KEY = 4'b1111;
    idle(5);
    rd(16'hFFF4, "kctrl_ovr", 16'h0005);
    step(1'b1, 1'b0, 16'hFFF4, 16'h0000);
    rd(16'hFFF4, "kctrl_ovrclr", 16'h0001);

    // commit coinciding with a data read: Ready stays, no Overrun
    KEY = 4'b1110;
    idle(4);
    step(1'b0, 1'b1, 16'hFFF0, 16'h0000);
    rd(16'hFFF4, "kctrl_coinc", 16'h0001);
    rd(16'hFFF0, "kdata_coinc", 16'h0001);

    // async reset in the middle of a debounce count
    KEY = 4'b1101;
    idle(4);
    RESET_N = 1'b0; KEY = 4'b1111; ADDR = 16'hFFF8;
    model_reset();
    #1;
    expect_out("arst_hex_dout", 0, 16'h0000);
    expect_out("arst_hex", 1, 16'h0000);
    expect_out("arst_ledr", 2, 16'h0000);
    expect_out("arst_ledg", 3, 16'h0000);
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    idle(10);
    rd(16'hFFF0, "arst_kdata", 16'h0000);
    rd(16'hFFF4, "arst_kctrl", 16'h0000);

    // randomized traffic against the model
    for (int it = 0; it < 800; it++) begin
      logic [15:0] a;
      logic [15:0] d;
      int op;
      int r;
      r = $urandom_range(0, 9);
      if (r < 8) a = 16'hFFF0 + 16'(2 * r) + 16'($urandom_range(0, 1));
      else if (r == 8) a = 16'($urandom);
      else a = 16'hFFF4 + 16'(2 * $urandom_range(0, 1));
      d = 16'($urandom);
      op = $urandom_range(0, 9);
      if (op < 4) step(1'b0, 1'($urandom), a, d);
      else if (op < 7) step(1'b1, 1'b0, a, d);
      else step(1'b0, 1'b0, a, d);
      expect_out("rand_dout", 0, exp_read(a));
      if ((it % 16) == 0) begin
        expect_out("rand_hex", 1, m_hex);
        expect_out("rand_ledr", 2, {6'h00, m_ledr});
        expect_out("rand_ledg", 3, {8'h00, m_ledg});
      end
      if ($urandom_range(0, 7) == 0) KEY = 4'($urandom);
      if ($urandom_range(0, 9) == 0) SW = 10'($urandom);
    end

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge CLK);
    if (sbq.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
